// File: rtl/countdown_timer_ctrl_if.sv
// Front-panel controls and display digits for the M:ST:SO countdown timer.
// The panel side drives the controls; the timer drives the digits and status.
interface countdown_timer_ctrl_if;
  logic       load;
  logic [3:0] preset_min;
  logic [2:0] preset_st;
  logic [3:0] preset_so;
  logic       start;
  logic       pause;
  logic       stop;
  logic [3:0] min;
  logic [2:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       done;

  modport master (
    output load, preset_min, preset_st, preset_so,
    output start, pause, stop,
    input  min, sec_tens, sec_ones, running, done
  );

  modport slave (
    input  load, preset_min, preset_st, preset_so,
    input  start, pause, stop,
    output min, sec_tens, sec_ones, running, done
  );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// BCD minutes:seconds countdown controller with prescaler and borrow cascade.
// Define COUNTDOWN_AUTORELOAD_EN to reload the preset on expiry instead of stopping.
module countdown_timer_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic                  clk,
  input  logic                  init,
  countdown_timer_ctrl_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    pre_min_q, pre_min_d;
  logic [2:0]    pre_st_q, pre_st_d;
  logic [3:0]    pre_so_q, pre_so_d;
  logic [3:0]    min_q, min_d;
  logic [2:0]    st_q, st_d;
  logic [3:0]    so_q, so_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;

  logic          tick;
  logic          zero;
  logic          expire;
  logic          b_so, b_st;
  logic [3:0]    so_dec, min_dec;
  logic [2:0]    st_dec;
  logic [3:0]    c_min, c_so;
  logic [2:0]    c_st;

  function automatic logic [3:0] clamp9(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  function automatic logic [2:0] clamp5(input logic [2:0] v);
    return (v > 3'd5) ? 3'd5 : v;
  endfunction

  always_comb begin
    c_min   = clamp9(bus.preset_min);
    c_st    = clamp5(bus.preset_st);
    c_so    = clamp9(bus.preset_so);
    tick    = (presc_q == LAST);
    zero    = (min_q == 4'd0) && (st_q == 3'd0) && (so_q == 4'd0);
    b_so    = (so_q == 4'd0);
    b_st    = b_so && (st_q == 3'd0);
    so_dec  = b_so ? 4'd9 : so_q - 4'd1;
    st_dec  = b_so ? ((st_q == 3'd0) ? 3'd5 : st_q - 3'd1) : st_q;
    min_dec = b_st ? min_q - 4'd1 : min_q;
    // RUN never holds 0:00, so only 0:01 can expire on a tick
    expire  = (min_q == 4'd0) && (st_q == 3'd0) && (so_q == 4'd1);
  end

  always_comb begin
    state_d   = state_q;
    pre_min_d = pre_min_q;
    pre_st_d  = pre_st_q;
    pre_so_d  = pre_so_q;
    min_d     = min_q;
    st_d      = st_q;
    so_d      = so_q;
    presc_d   = presc_q;
`ifdef COUNTDOWN_AUTORELOAD_EN
    done_d    = 1'b0;
`else
    done_d    = done_q;
`endif

    if (bus.stop) begin
      state_d = S_IDLE;
      min_d   = pre_min_q;
      st_d    = pre_st_q;
      so_d    = pre_so_q;
      presc_d = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.load) begin
            pre_min_d = c_min;
            pre_st_d  = c_st;
            pre_so_d  = c_so;
            min_d     = c_min;
            st_d      = c_st;
            so_d      = c_so;
            state_d   = S_IDLE;
            done_d    = 1'b0;
          end else if (state_q == S_IDLE && bus.start && !zero) begin
            state_d = S_RUN;
            presc_d = '0;
          end
        end
        S_RUN: begin
          if (bus.pause) begin
            state_d = S_PAUSE;
          end else if (tick) begin
            presc_d = '0;
            if (expire) begin
              done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
              min_d  = pre_min_q;
              st_d   = pre_st_q;
              so_d   = pre_so_q;
`else
              min_d   = 4'd0;
              st_d    = 3'd0;
              so_d    = 4'd0;
              state_d = S_DONE;
`endif
            end else begin
              min_d = min_dec;
              st_d  = st_dec;
              so_d  = so_dec;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        S_PAUSE: begin
          if (bus.start) begin
            state_d = S_RUN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      state_q   <= S_IDLE;
      pre_min_q <= '0;
      pre_st_q  <= '0;
      pre_so_q  <= '0;
      min_q     <= '0;
      st_q      <= '0;
      so_q      <= '0;
      presc_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_min_q <= pre_min_d;
      pre_st_q  <= pre_st_d;
      pre_so_q  <= pre_so_d;
      min_q     <= min_d;
      st_q      <= st_d;
      so_q      <= so_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
    end
  end

  assign bus.min      = min_q;
  assign bus.sec_tens = st_q;
  assign bus.sec_ones = so_q;
  assign bus.running  = (state_q == S_RUN);
  assign bus.done     = done_q;

endmodule
